// File: rtl/pll_mode_reconfig.sv
// PAL/NTSC reconfiguration sequencer for the video PLL reconfig core.
// Writes MODE, M, K, C0 and START over Avalon-MM, then waits for lock or times out.
module pll_mode_reconfig #(
    parameter logic [31:0] M_PAL    = 32'h00020504,
    parameter logic [31:0] K_PAL    = 32'd343828281,
    parameter logic [31:0] C0_PAL   = 32'h00000404,
    parameter logic [31:0] M_NTSC   = 32'h00020504,
    parameter logic [31:0] K_NTSC   = 32'd702812831,
    parameter logic [31:0] C0_NTSC  = 32'h00000404,
    parameter logic [23:0] LOCK_TMO = 24'd5000000
) (
    input  logic        i_refclk,
    input  logic        i_rst,
    input  logic        i_ntsc,
    input  logic        i_pll_locked,
    output logic [5:0]  o_mgmt_address,
    output logic        o_mgmt_write,
    output logic [31:0] o_mgmt_writedata,
    input  logic        i_mgmt_waitrequest,
    output logic        o_busy,
    output logic        o_cur_ntsc,
    output logic        o_err
);

    localparam int unsigned CNT_W    = 24;
    localparam int unsigned LOCK_MIN = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_MODE, S_WR_M, S_WR_K, S_WR_C0, S_WR_START, S_WAIT_LOCK
    } state_t;

    state_t             r_state, w_nxt_state;
    logic               r_gap, w_nxt_gap;
    logic               r_target, w_nxt_target;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic               r_ntsc_meta, r_ntsc_s, r_lock_meta, r_lock_s;
    logic [5:0]         r_mgmt_address, w_nxt_address;
    logic               r_mgmt_write, w_nxt_write;
    logic [31:0]        r_mgmt_writedata, w_nxt_writedata;
    logic               r_busy, w_nxt_busy;
    logic               r_cur_ntsc, w_nxt_cur;
    logic               r_err, w_nxt_err;

    logic w_accept, w_lock_ok, w_tmo;

    assign w_accept  = r_mgmt_write & ~i_mgmt_waitrequest;
    assign w_lock_ok = r_lock_s && (r_cnt >= CNT_W'(LOCK_MIN));
    assign w_tmo     = (r_cnt == (LOCK_TMO - 24'd1));

    // State, synchronisers and registered outputs
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_gap            <= 1'b0;
            r_target         <= 1'b0;
            r_cnt            <= '0;
            r_ntsc_meta      <= 1'b0;
            r_ntsc_s         <= 1'b0;
            r_lock_meta      <= 1'b0;
            r_lock_s         <= 1'b0;
            r_mgmt_address   <= 6'd0;
            r_mgmt_write     <= 1'b0;
            r_mgmt_writedata <= 32'd0;
            r_busy           <= 1'b0;
            r_cur_ntsc       <= 1'b0;
            r_err            <= 1'b0;
        end else begin
            r_state          <= w_nxt_state;
            r_gap            <= w_nxt_gap;
            r_target         <= w_nxt_target;
            r_cnt            <= w_nxt_cnt;
            r_ntsc_meta      <= i_ntsc;
            r_ntsc_s         <= r_ntsc_meta;
            r_lock_meta      <= i_pll_locked;
            r_lock_s         <= r_lock_meta;
            r_mgmt_address   <= w_nxt_address;
            r_mgmt_write     <= w_nxt_write;
            r_mgmt_writedata <= w_nxt_writedata;
            r_busy           <= w_nxt_busy;
            r_cur_ntsc       <= w_nxt_cur;
            r_err            <= w_nxt_err;
        end
    end

    // Next state; an accepted write leaves one strobe-free cycle before the next
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gap   = 1'b0;
        unique case (r_state)
            S_IDLE:      if (r_lock_s && (r_ntsc_s != r_cur_ntsc)) w_nxt_state = S_WR_MODE;
            S_WR_MODE:   if (w_accept) begin w_nxt_state = S_WR_M;  w_nxt_gap = 1'b1; end
            S_WR_M:      if (w_accept) begin w_nxt_state = S_WR_K;  w_nxt_gap = 1'b1; end
            S_WR_K:      if (w_accept) begin w_nxt_state = S_WR_C0; w_nxt_gap = 1'b1; end
            S_WR_C0:     if (w_accept) begin w_nxt_state = S_WR_START; w_nxt_gap = 1'b1; end
            S_WR_START:  if (w_accept) w_nxt_state = S_WAIT_LOCK;
            S_WAIT_LOCK: if (w_lock_ok || w_tmo) w_nxt_state = S_IDLE;
            default:     w_nxt_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_nxt_target    = r_target;
        w_nxt_cnt       = '0;
        w_nxt_busy      = r_busy;
        w_nxt_cur       = r_cur_ntsc;
        w_nxt_err       = r_err;
        w_nxt_address   = 6'd0;
        w_nxt_writedata = 32'd0;
        w_nxt_write     = 1'b0;

        if (r_state == S_IDLE && w_nxt_state == S_WR_MODE) begin
            w_nxt_target = r_ntsc_s;
            w_nxt_busy   = 1'b1;
        end

        if (r_state == S_WAIT_LOCK) begin
            if (w_lock_ok) begin
                w_nxt_cur  = r_target;
                w_nxt_busy = 1'b0;
                w_nxt_err  = 1'b0;
            end else if (w_tmo) begin
                w_nxt_cur  = r_target;
                w_nxt_busy = 1'b0;
                w_nxt_err  = 1'b1;
            end else begin
                w_nxt_cnt  = r_cnt + 24'd1;
            end
        end

        unique case (w_nxt_state)
            S_WR_MODE: begin
                w_nxt_address   = 6'h00;
                w_nxt_writedata = 32'd0;
                w_nxt_write     = ~w_nxt_gap;
            end
            S_WR_M: begin
                w_nxt_address   = 6'h04;
                w_nxt_writedata = w_nxt_target ? M_NTSC : M_PAL;
                w_nxt_write     = ~w_nxt_gap;
            end
            S_WR_K: begin
                w_nxt_address   = 6'h07;
                w_nxt_writedata = w_nxt_target ? K_NTSC : K_PAL;
                w_nxt_write     = ~w_nxt_gap;
            end
            S_WR_C0: begin
                w_nxt_address   = 6'h05;
                w_nxt_writedata = w_nxt_target ? C0_NTSC : C0_PAL;
                w_nxt_write     = ~w_nxt_gap;
            end
            S_WR_START: begin
                w_nxt_address   = 6'h02;
                w_nxt_writedata = 32'd1;
                w_nxt_write     = ~w_nxt_gap;
            end
            default: begin
                w_nxt_address   = 6'd0;
                w_nxt_writedata = 32'd0;
                w_nxt_write     = 1'b0;
            end
        endcase
    end

    assign o_mgmt_address   = r_mgmt_address;
    assign o_mgmt_write     = r_mgmt_write;
    assign o_mgmt_writedata = r_mgmt_writedata;
    assign o_busy           = r_busy;
    assign o_cur_ntsc       = r_cur_ntsc;
    assign o_err            = r_err;

endmodule

// File: tb/tb_pll_mode_reconfig.sv
// Bench for pll_mode_reconfig: Avalon slave and PLL lock model, directed steps plus random mode switches.
module tb_pll_mode_reconfig;

    localparam logic [31:0] M_PAL   = 32'h00020504;
    localparam logic [31:0] K_PAL   = 32'd343828281;
    localparam logic [31:0] C0_PAL  = 32'h00000404;
    localparam logic [31:0] M_NTSC  = 32'h00020504;
    localparam logic [31:0] K_NTSC  = 32'd702812831;
    localparam logic [31:0] C0_NTSC = 32'h00000404;
    localparam int          TMO     = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ntsc = 1'b0;
    logic        pll_locked = 1'b1;
    logic        waitreq = 1'b0;
    logic [5:0]  o_mgmt_address;
    logic        o_mgmt_write;
    logic [31:0] o_mgmt_writedata;
    logic        o_busy, o_cur_ntsc, o_err;

    pll_mode_reconfig #(
        .M_PAL(M_PAL), .K_PAL(K_PAL), .C0_PAL(C0_PAL),
        .M_NTSC(M_NTSC), .K_NTSC(K_NTSC), .C0_NTSC(C0_NTSC),
        .LOCK_TMO(24'(TMO))
    ) dut (
        .i_refclk(clk), .i_rst(rst), .i_ntsc(ntsc), .i_pll_locked(pll_locked),
        .o_mgmt_address(o_mgmt_address), .o_mgmt_write(o_mgmt_write),
        .o_mgmt_writedata(o_mgmt_writedata), .i_mgmt_waitrequest(waitreq),
        .o_busy(o_busy), .o_cur_ntsc(o_cur_ntsc), .o_err(o_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        int          len;
        int          gap;
    } wr_t;

    wr_t  cap [256];
    int   cap_n = 0;
    int   rd = 0;
    int   checks = 0;
    int   errors = 0;

    logic [5:0] stall_addr = 6'h3f;
    int   stall_len = 0;
    bit   rand_wr = 1'b0;
    bit   lock_never = 1'b0;
    int   lock_delay = 20;

    bit          pending = 1'b0;
    logic [5:0]  prev_a = 6'd0;
    logic [31:0] prev_d = 32'd0;
    int   strobe_len = 0;
    int   gap_cnt = 0;
    int   lock_timer = 0;
    bit   wl_active = 1'b0;
    int   wl_count = 0;
    int   wl_len = 0;
    int   wr_cycles = 0;
    int   busy_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_a(input int i);
        case (i)
            0: return 6'h00;
            1: return 6'h04;
            2: return 6'h07;
            3: return 6'h05;
            default: return 6'h02;
        endcase
    endfunction

    function automatic logic [31:0] exp_d(input bit mode, input int i);
        case (i)
            0: return 32'd0;
            1: return mode ? M_NTSC : M_PAL;
            2: return mode ? K_NTSC : K_PAL;
            3: return mode ? C0_NTSC : C0_PAL;
            default: return 32'd1;
        endcase
    endfunction

    // Lock raised d cycles after START acceptance is seen 2 cycles later, but never before the 17th cycle
    function automatic int exp_wl(input int d);
        return (d + 2 > 17) ? d + 2 : 17;
    endfunction

    // Avalon slave, PLL lock model and protocol monitor, all on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            pending    = 1'b0;
            strobe_len = 0;
            gap_cnt    = 0;
            wl_active  = 1'b0;
            lock_timer = 0;
            waitreq    = 1'b0;
        end else begin
            if (o_busy) busy_cycles++;
            if (wl_active) begin
                if (o_busy) wl_count++;
                else begin
                    wl_active = 1'b0;
                    wl_len    = wl_count;
                end
            end
            if (lock_timer > 0) lock_timer--;
            if (lock_timer == 0 && !lock_never) pll_locked = 1'b1;
            if (o_mgmt_write) begin
                wr_cycles++;
                if (pending) begin
                    check("addr_stable", 32'(o_mgmt_address), 32'(prev_a));
                    check("data_stable", o_mgmt_writedata, prev_d);
                end
                strobe_len++;
                if (o_mgmt_address == stall_addr && strobe_len <= stall_len) waitreq = 1'b1;
                else if (rand_wr) waitreq = ($urandom_range(0, 2) == 0);
                else waitreq = 1'b0;
                if (!waitreq) begin
                    if (cap_n < 256) begin
                        cap[cap_n] = '{o_mgmt_address, o_mgmt_writedata, strobe_len, gap_cnt};
                        cap_n++;
                    end
                    if (o_mgmt_address == 6'h02) begin
                        pll_locked = 1'b0;
                        lock_timer = lock_delay;
                        wl_active  = 1'b1;
                        wl_count   = 0;
                    end
                    pending    = 1'b0;
                    strobe_len = 0;
                    gap_cnt    = 0;
                end else begin
                    pending = 1'b1;
                    prev_a  = o_mgmt_address;
                    prev_d  = o_mgmt_writedata;
                end
            end else begin
                if (pending) check("wr_held", 32'(o_mgmt_write), 32'd1);
                pending = 1'b0;
                waitreq = 1'b0;
                gap_cnt++;
            end
        end
    end

    task automatic expect_seq(input bit mode);
        wr_t w;
        for (int i = 0; i < 5; i++) begin
            if (rd < cap_n) begin
                w = cap[rd];
                check(mode ? "ntsc_addr" : "pal_addr", 32'(w.a), 32'(exp_a(i)));
                check(mode ? "ntsc_data" : "pal_data", w.d, exp_d(mode, i));
                if (i > 0) check("idle_gap", 32'(w.gap), 32'd1);
                rd++;
            end else begin
                check("seq_count", 32'(cap_n), 32'(rd + 1));
            end
        end
    endtask

    task automatic run_until_quiet(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = o_busy ? 0 : quiet + 1;
        end
        check("quiet_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_wr_addr(input logic [5:0] addr, input int budget);
        int n = 0;
        while (!(o_mgmt_write && o_mgmt_address == addr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wr_addr_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int model_cur;
        int m;
        int d;

        rst  = 1'b1;
        ntsc = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_write", 32'(o_mgmt_write), 32'd0);
        check("rst_addr",  32'(o_mgmt_address), 32'd0);
        check("rst_data",  o_mgmt_writedata, 32'd0);
        check("rst_busy",  32'(o_busy), 32'd0);
        check("rst_cur",   32'(o_cur_ntsc), 32'd0);
        check("rst_err",   32'(o_err), 32'd0);
        rst = 1'b0;

        // PAL requested after reset: nothing to do
        repeat (30) @(negedge clk);
        check("pal_wr_cycles", 32'(wr_cycles), 32'd0);
        check("pal_busy_cycles", 32'(busy_cycles), 32'd0);
        check("pal_cap", 32'(cap_n), 32'd0);

        // Switch to NTSC, lock 20 cycles after START
        lock_delay = 20;
        ntsc = 1'b1;
        run_until_quiet(400);
        expect_seq(1'b1);
        check("ntsc_cur", 32'(o_cur_ntsc), 32'd1);
        check("ntsc_busy", 32'(o_busy), 32'd0);
        check("ntsc_err", 32'(o_err), 32'd0);
        check("ntsc_wl_len", 32'(wl_len), 32'(exp_wl(20)));

        // PAL with a 5-cycle stall on the K write
        stall_addr = 6'h07;
        stall_len  = 5;
        ntsc = 1'b0;
        run_until_quiet(400);
        expect_seq(1'b0);
        check("stall_k_len", 32'(cap[rd-3].len), 32'd6);
        check("stall_c0_len", 32'(cap[rd-2].len), 32'd1);
        check("stall_cur", 32'(o_cur_ntsc), 32'd0);
        stall_len = 0;

        // Lock never returns: timeout exactly TMO cycles into WAIT_LOCK
        lock_never = 1'b1;
        ntsc = 1'b1;
        run_until_quiet(600);
        expect_seq(1'b1);
        check("tmo_wl_len", 32'(wl_len), 32'(TMO));
        check("tmo_err", 32'(o_err), 32'd1);
        check("tmo_busy", 32'(o_busy), 32'd0);
        check("tmo_cur", 32'(o_cur_ntsc), 32'd1);

        // Successful PAL switch clears err; short lock delay hits the 16-cycle mask
        lock_never = 1'b0;
        lock_delay = 5;
        ntsc = 1'b0;
        run_until_quiet(600);
        expect_seq(1'b0);
        check("clr_err", 32'(o_err), 32'd0);
        check("clr_cur", 32'(o_cur_ntsc), 32'd0);
        check("clr_wl_len", 32'(wl_len), 32'(exp_wl(5)));

        // ntsc 0->1->0 during WR_M: NTSC completes, then PAL
        lock_delay = 10;
        ntsc = 1'b1;
        wait_wr_addr(6'h04, 200);
        ntsc = 1'b0;
        run_until_quiet(1000);
        expect_seq(1'b1);
        expect_seq(1'b0);
        check("tog_cur", 32'(o_cur_ntsc), 32'd0);
        check("tog_no_extra", 32'(cap_n), 32'(rd));

        // Async reset while the C0 write is stalled
        stall_addr = 6'h05;
        stall_len  = 1000;
        ntsc = 1'b1;
        wait_wr_addr(6'h05, 200);
        #3 rst = 1'b1;
        #1;
        check("arst_write", 32'(o_mgmt_write), 32'd0);
        check("arst_cur", 32'(o_cur_ntsc), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        stall_len = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("arst_partial", 32'(cap_n - rd), 32'd3);
        rd = cap_n;
        run_until_quiet(600);
        expect_seq(1'b1);
        check("arst_cur_end", 32'(o_cur_ntsc), 32'd1);

        // Random mode requests, random waitrequest and lock delays
        rand_wr   = 1'b1;
        model_cur = 1;
        for (int it = 0; it < 12; it++) begin
            m = int'($urandom_range(0, 1));
            d = int'($urandom_range(1, 40));
            lock_delay = d;
            ntsc = m[0];
            run_until_quiet(1500);
            if (m != model_cur) begin
                expect_seq(m[0]);
                check("rnd_wl_len", 32'(wl_len), 32'(exp_wl(d)));
                model_cur = m;
            end
            check("rnd_cur", 32'(o_cur_ntsc), 32'(model_cur));
            check("rnd_err", 32'(o_err), 32'd0);
            check("rnd_no_extra", 32'(cap_n), 32'(rd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
